// File: rtl/ad2s1210_pkg.sv
// Shared AD2S1210 definitions: FSM state codes, status codes, address floor, config beat layout.
// AD2S1210_CONFIG_VERIFY_EN enables the read-back states in the writer.
package ad2s1210_pkg;

    localparam int unsigned STATE_W = 4;
    typedef logic [STATE_W-1:0] state_t;

    // SEND_x is always immediately followed by its WAIT_x encoding
    localparam state_t ST_IDLE          = 4'd0;
    localparam state_t ST_SETUP         = 4'd1;
    localparam state_t ST_SEND_ADDR     = 4'd2;
    localparam state_t ST_WAIT_ADDR     = 4'd3;
    localparam state_t ST_SEND_DATA     = 4'd4;
    localparam state_t ST_WAIT_DATA     = 4'd5;
    localparam state_t ST_SEND_RB_ADDR  = 4'd6;
    localparam state_t ST_WAIT_RB_ADDR  = 4'd7;
    localparam state_t ST_SEND_RB_DUMMY = 4'd8;
    localparam state_t ST_WAIT_RB_DUMMY = 4'd9;
    localparam state_t ST_HOLD          = 4'd10;
    localparam state_t ST_DONE          = 4'd11;

    localparam logic [1:0] STATUS_OK       = 2'b00;
    localparam logic [1:0] STATUS_BAD_ADDR = 2'b01;
    localparam logic [1:0] STATUS_TIMEOUT  = 2'b10;
    localparam logic [1:0] STATUS_MISMATCH = 2'b11;

    localparam logic [7:0] ADDR_FLOOR = 8'h80;

    typedef struct packed {
        logic [7:0] addr;
        logic [7:0] value;
    } config_beat_t;

    function automatic logic is_reg_addr(input logic [7:0] addr);
        return addr >= ADDR_FLOOR;
    endfunction

endpackage

// File: rtl/ad2s1210_cycle_timer.sv
// Loadable down-counter; expired_o is high once the count has reached zero.
module ad2s1210_cycle_timer #(
    parameter int unsigned W = 11
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         load_i,
    input  logic [W-1:0] value_i,
    output logic         expired_o
);

    logic [W-1:0] count_q, count_d;
    logic         expired_q;

    always_comb begin
        count_d = count_q;
        if (load_i) begin
            count_d = value_i;
        end else if (count_q != '0) begin
            count_d = count_q - W'(1);
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            count_q   <= '0;
            expired_q <= 1'b1;
        end else begin
            count_q   <= count_d;
            expired_q <= (count_d == '0);
        end
    end

    assign expired_o = expired_q;

endmodule

// File: rtl/ad2s1210_config_writer.sv
// Writes one AD2S1210 register over SPI with mode-pin setup/hold framing.
// Define AD2S1210_CONFIG_VERIFY_EN to read the register back and compare.
module ad2s1210_config_writer
    import ad2s1210_pkg::*;
#(
    parameter int unsigned MODE_SETUP_CYCLES = 8,
    parameter int unsigned TIMEOUT_CYCLES    = 1024
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [15:0] config_in_data,
    input  logic        config_in_valid,
    output logic        config_in_ready,
    output logic [31:0] spi_transfer_data,
    output logic        spi_transfer_valid,
    input  logic        spi_transfer_ready,
    input  logic [31:0] spi_data_in,
    output logic [1:0]  mode,
    output logic        busy,
    output logic [7:0]  status_out_data,
    output logic [1:0]  status_out_user,
    output logic        status_out_valid,
    input  logic        status_out_ready
);

    localparam int unsigned MAX_CYCLES = (MODE_SETUP_CYCLES > TIMEOUT_CYCLES) ?
                                         MODE_SETUP_CYCLES : TIMEOUT_CYCLES;
    localparam int unsigned TW = $clog2(MAX_CYCLES + 1);
    localparam logic [TW-1:0] SETUP_LOAD =
        TW'((MODE_SETUP_CYCLES > 0) ? MODE_SETUP_CYCLES - 1 : 0);
    localparam logic [TW-1:0] TIMEOUT_LOAD =
        TW'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);
`ifdef AD2S1210_CONFIG_VERIFY_EN
    localparam state_t ST_LAST_WAIT = ST_WAIT_RB_DUMMY;
`else
    localparam state_t ST_LAST_WAIT = ST_WAIT_DATA;
`endif

    state_t       state_q, state_d;
    logic [7:0]   addr_q, addr_d;
    logic [7:0]   value_q, value_d;
    logic [1:0]   code_q, code_d;
    logic [7:0]   rb_q, rb_d;
    logic         seen_low_q, seen_low_d;
    logic         spi_valid_q, spi_valid_d;
    logic [7:0]   spi_byte_q, spi_byte_d;
    logic [1:0]   mode_q, mode_d;
    logic         busy_q, busy_d;
    logic         ready_q, ready_d;
    logic         status_valid_q, status_valid_d;

    config_beat_t beat_c;
    logic [7:0]   send_byte_c;
    logic         timeout_c;
    logic         tmr_load_c;
    logic [TW-1:0] tmr_value_c;
    logic         tmr_expired;
    logic         unused_rx_bits;

`ifdef AD2S1210_CONFIG_VERIFY_EN
    assign unused_rx_bits = ^spi_data_in[31:8];
`else
    assign unused_rx_bits = ^spi_data_in;
`endif

    assign beat_c = config_beat_t'(config_in_data);

    ad2s1210_cycle_timer #(.W(TW)) u_timer (
        .clk_i     (clock),
        .rst_i     (reset),
        .load_i    (tmr_load_c),
        .value_i   (tmr_value_c),
        .expired_o (tmr_expired)
    );

    // Byte driven by the current SEND state
    always_comb begin
        case (state_q)
            ST_SEND_DATA:     send_byte_c = value_q;
            ST_SEND_RB_DUMMY: send_byte_c = 8'h00;
            default:          send_byte_c = addr_q;
        endcase
    end

    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        value_d     = value_q;
        code_d      = code_q;
        rb_d        = rb_q;
        seen_low_d  = seen_low_q;
        spi_valid_d = 1'b0;
        spi_byte_d  = spi_byte_q;
        tmr_load_c  = 1'b0;
        tmr_value_c = SETUP_LOAD;
        timeout_c   = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (config_in_valid && ready_q) begin
                    addr_d  = beat_c.addr;
                    value_d = beat_c.value;
                    rb_d    = 8'h00;
                    if (is_reg_addr(beat_c.addr)) begin
                        code_d     = STATUS_OK;
                        state_d    = ST_SETUP;
                        tmr_load_c = 1'b1;
                    end else begin
                        code_d  = STATUS_BAD_ADDR;
                        state_d = ST_DONE;
                    end
                end
            end
            ST_SETUP: begin
                if (tmr_expired) begin
                    state_d     = ST_SEND_ADDR;
                    tmr_load_c  = 1'b1;
                    tmr_value_c = TIMEOUT_LOAD;
                end
            end
`ifdef AD2S1210_CONFIG_VERIFY_EN
            ST_SEND_ADDR, ST_SEND_DATA, ST_SEND_RB_ADDR, ST_SEND_RB_DUMMY: begin
`else
            ST_SEND_ADDR, ST_SEND_DATA: begin
`endif
                // Timeout budget spans the SEND and WAIT halves of one transfer
                if (spi_transfer_ready && !spi_valid_q) begin
                    spi_valid_d = 1'b1;
                    spi_byte_d  = send_byte_c;
                    seen_low_d  = 1'b0;
                    state_d     = state_q + 4'd1;
                end else if (tmr_expired) begin
                    timeout_c = 1'b1;
                end
            end
`ifdef AD2S1210_CONFIG_VERIFY_EN
            ST_WAIT_ADDR, ST_WAIT_DATA, ST_WAIT_RB_ADDR, ST_WAIT_RB_DUMMY: begin
`else
            ST_WAIT_ADDR, ST_WAIT_DATA: begin
`endif
                if (!spi_transfer_ready) begin
                    seen_low_d = 1'b1;
                end
                if (spi_transfer_ready && seen_low_q) begin
                    tmr_load_c  = 1'b1;
                    tmr_value_c = TIMEOUT_LOAD;
                    case (state_q)
                        ST_WAIT_ADDR: state_d = ST_SEND_DATA;
`ifdef AD2S1210_CONFIG_VERIFY_EN
                        ST_WAIT_DATA:    state_d = ST_SEND_RB_ADDR;
                        ST_WAIT_RB_ADDR: state_d = ST_SEND_RB_DUMMY;
                        ST_WAIT_RB_DUMMY: begin
                            rb_d        = spi_data_in[7:0];
                            code_d      = (spi_data_in[7:0] == value_q) ?
                                          STATUS_OK : STATUS_MISMATCH;
                            state_d     = ST_HOLD;
                            tmr_value_c = SETUP_LOAD;
                        end
`else
                        ST_WAIT_DATA: begin
                            state_d     = ST_HOLD;
                            tmr_value_c = SETUP_LOAD;
                        end
`endif
                        default: state_d = ST_IDLE;
                    endcase
                end else if (tmr_expired) begin
                    timeout_c = 1'b1;
                end
            end
            ST_HOLD: begin
                if (tmr_expired) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                if (status_out_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (timeout_c) begin
            code_d      = STATUS_TIMEOUT;
            state_d     = ST_HOLD;
            tmr_load_c  = 1'b1;
            tmr_value_c = SETUP_LOAD;
        end

        // Outputs registered from the next state so they align with state_q
        mode_d         = (state_d >= ST_SETUP && state_d <= ST_LAST_WAIT) ? 2'b11 : 2'b00;
        busy_d         = (state_d != ST_IDLE);
        ready_d        = (state_d == ST_IDLE);
        status_valid_d = (state_d == ST_DONE);
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q        <= ST_IDLE;
            addr_q         <= 8'h00;
            value_q        <= 8'h00;
            code_q         <= STATUS_OK;
            rb_q           <= 8'h00;
            seen_low_q     <= 1'b0;
            spi_valid_q    <= 1'b0;
            spi_byte_q     <= 8'h00;
            mode_q         <= 2'b00;
            busy_q         <= 1'b0;
            ready_q        <= 1'b0;
            status_valid_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            addr_q         <= addr_d;
            value_q        <= value_d;
            code_q         <= code_d;
            rb_q           <= rb_d;
            seen_low_q     <= seen_low_d;
            spi_valid_q    <= spi_valid_d;
            spi_byte_q     <= spi_byte_d;
            mode_q         <= mode_d;
            busy_q         <= busy_d;
            ready_q        <= ready_d;
            status_valid_q <= status_valid_d;
        end
    end

    assign config_in_ready    = ready_q;
    assign spi_transfer_data  = {24'h000000, spi_byte_q};
    assign spi_transfer_valid = spi_valid_q;
    assign mode               = mode_q;
    assign busy               = busy_q;
    assign status_out_data    = rb_q;
    assign status_out_user    = code_q;
    assign status_out_valid   = status_valid_q;

endmodule
